note_scheduler: RTL and testbench

- Sequences the falling-note datapath of the three-lane rhythm game.
- Reads a beat-indexed song pattern from an external ROM and allocates notes into a fixed pool of per-lane note slots.
- Advances slot positions on a movement tick, retires notes at the bottom of the screen, and arbitrates player hit requests against the hit window.
- Sits between the clock divider/buttons and the VGA pixel-compare logic; the pixel logic consumes slot_active/slot_pos.

---
 rtl/note_sched_pkg.sv | 26 ++
 rtl/note_lane.sv | 115 +++++++++++
 rtl/note_scheduler.sv | 124 ++++++++++++
 tb/tb_note_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/note_sched_pkg.sv
// note_sched_pkg: shared definitions for the note scheduler.
//   state_t  - top-level FSM encoding (IDLE=0, PLAY=1, DONE=2)
//   DEF_*    - default geometry, timing and hit-window constants
//   slot_idx - flat slot index (lane*slots + slot) used by the packed outputs
package note_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_LANES      = 3;
  localparam int DEF_SLOTS      = 3;
  localparam int DEF_POS_W      = 10;
  localparam int DEF_BOTTOM     = 520;
  localparam int DEF_BEAT_TICKS = 32;
  localparam int DEF_SONG_LEN   = 8;
  localparam int DEF_HIT_LO     = 440;
  localparam int DEF_HIT_HI     = 480;

  function automatic int slot_idx(input int lane, input int slot, input int slots);
    return lane * slots + slot;
  endfunction

endpackage

// File: rtl/note_lane.sv
// note_lane: the note slots of one lane.
//   clk, reset_n  - clock, synchronous active-low reset
//   flush         - clear every slot and pulse (abort / not playing)
//   tick          - advance / retire strobe (already gated to PLAY)
//   spawn         - place a new note at pos 0 in the lowest free slot
//   hit_req       - player hit request (already gated to PLAY)
//   active, pos   - registered slot occupancy and positions
//   active_nxt    - occupancy after this cycle's update (end-of-song detection)
//   hit, miss, ovf- registered one-cycle result pulses
module note_lane
  import note_sched_pkg::*;
#(
  parameter int SLOTS  = DEF_SLOTS,
  parameter int POS_W  = DEF_POS_W,
  parameter int BOTTOM = DEF_BOTTOM,
  parameter int HIT_LO = DEF_HIT_LO,
  parameter int HIT_HI = DEF_HIT_HI
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        tick,
  input  logic                        spawn,
  input  logic                        hit_req,
  output logic [SLOTS-1:0]            active,
  output logic [SLOTS-1:0][POS_W-1:0] pos,
  output logic [SLOTS-1:0]            active_nxt,
  output logic                        hit,
  output logic                        miss,
  output logic                        ovf
);

  logic [SLOTS-1:0][POS_W-1:0] pos_nxt;
  logic                        cand_vld;
  logic [SLOTS-1:0]            cand_oh;
  logic [POS_W-1:0]            cand_pos;
  logic                        free_vld;
  logic [SLOTS-1:0]            free_oh;
  logic                        hit_ok;
  logic                        retire;

  // Hit candidate: deepest in-window note; strict '>' keeps the lowest index on ties.
  always_comb begin
    cand_vld = 1'b0;
    cand_oh  = '0;
    cand_pos = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (active[s] && pos[s] >= POS_W'(HIT_LO) && pos[s] <= POS_W'(HIT_HI) &&
          (!cand_vld || pos[s] > cand_pos)) begin
        cand_vld   = 1'b1;
        cand_oh    = '0;
        cand_oh[s] = 1'b1;
        cand_pos   = pos[s];
      end
    end
  end

  // Lowest free slot, judged on registered occupancy so slots vacated this
  // cycle (retire or hit) are not reused until the next spawn.
  always_comb begin
    free_vld = 1'b0;
    free_oh  = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (!active[s]) begin
        free_vld   = 1'b1;
        free_oh    = '0;
        free_oh[s] = 1'b1;
      end
    end
  end

  always_comb begin
    hit_ok     = hit_req && cand_vld;
    retire     = 1'b0;
    active_nxt = active;
    pos_nxt    = pos;
    for (int s = 0; s < SLOTS; s++) begin
      // Hit uses pre-tick positions; the hit slot is freed instead of advanced.
      if (hit_ok && cand_oh[s]) begin
        active_nxt[s] = 1'b0;
        pos_nxt[s]    = '0;
      end else if (tick && active[s]) begin
        if (pos[s] == POS_W'(BOTTOM)) begin
          active_nxt[s] = 1'b0;
          pos_nxt[s]    = '0;
          retire        = 1'b1;
        end else begin
          pos_nxt[s] = pos[s] + 1'b1;
        end
      end
      // A free slot is inactive, so it never collides with the branches above.
      if (spawn && free_oh[s]) begin
        active_nxt[s] = 1'b1;
        pos_nxt[s]    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      active <= '0;
      pos    <= '0;
      hit    <= 1'b0;
      miss   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      active <= active_nxt;
      pos    <= pos_nxt;
      hit    <= hit_ok;
      miss   <= retire || (hit_req && !cand_vld);
      ovf    <= spawn && !free_vld;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: falling-note sequencer for the three-lane rhythm game.
//   clk, reset_n    - clock, synchronous active-low reset
//   tick            - one-cycle movement / beat strobe
//   start, abort    - play request / return to IDLE and flush
//   song_data       - lane mask from the async song ROM at song_addr
//   song_addr       - current beat index
//   hit_req         - per-lane hit request pulses
//   slot_active     - occupancy, index lane*SLOTS+slot
//   slot_pos        - packed positions, same indexing
//   hit_pulse, miss_pulse, overflow - registered one-cycle result pulses
//   state           - IDLE=0, PLAY=1, DONE=2
module note_scheduler
  import note_sched_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int SLOTS      = DEF_SLOTS,
  parameter int POS_W      = DEF_POS_W,
  parameter int BOTTOM     = DEF_BOTTOM,
  parameter int BEAT_TICKS = DEF_BEAT_TICKS,
  parameter int SONG_LEN   = DEF_SONG_LEN,
  parameter int HIT_LO     = DEF_HIT_LO,
  parameter int HIT_HI     = DEF_HIT_HI,
  localparam int AW        = $clog2(SONG_LEN),
  localparam int BW        = $clog2(BEAT_TICKS),
  localparam int IW        = $clog2(SONG_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           abort,
  input  logic [LANES-1:0]               song_data,
  output logic [AW-1:0]                  song_addr,
  input  logic [LANES-1:0]               hit_req,
  output logic [LANES*SLOTS-1:0]         slot_active,
  output logic [LANES*SLOTS*POS_W-1:0]   slot_pos,
  output logic [LANES-1:0]               hit_pulse,
  output logic [LANES-1:0]               miss_pulse,
  output logic [LANES-1:0]               overflow,
  output logic [1:0]                     state
);

  state_t                               st;
  logic [BW-1:0]                        beat_cnt;
  logic [IW-1:0]                        beat_idx;   // one wider than song_addr so it can hold SONG_LEN
  logic                                 play;
  logic                                 song_end;
  logic                                 end_nxt;
  logic                                 spawn_beat;
  logic [LANES-1:0][SLOTS-1:0]          lane_act;
  logic [LANES-1:0][SLOTS-1:0]          lane_act_nxt;
  logic [LANES-1:0][SLOTS-1:0][POS_W-1:0] lane_pos;

  assign play       = (st == ST_PLAY) && !abort;
  assign song_end   = (beat_idx == IW'(SONG_LEN));
  assign spawn_beat = play && tick && (beat_cnt == '0) && !song_end;
  assign end_nxt    = song_end || (spawn_beat && beat_idx == IW'(SONG_LEN - 1));
  // Once the song is exhausted the ROM index wraps to 0; no spawn reads it then.
  assign song_addr  = beat_idx[AW-1:0];
  assign state      = st;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_lane #(
      .SLOTS (SLOTS),
      .POS_W (POS_W),
      .BOTTOM(BOTTOM),
      .HIT_LO(HIT_LO),
      .HIT_HI(HIT_HI)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (!play),
      .tick      (play && tick),
      .spawn     (spawn_beat && song_data[l]),
      .hit_req   (play && hit_req[l]),
      .active    (lane_act[l]),
      .pos       (lane_pos[l]),
      .active_nxt(lane_act_nxt[l]),
      .hit       (hit_pulse[l]),
      .miss      (miss_pulse[l]),
      .ovf       (overflow[l])
    );
    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      assign slot_active[slot_idx(l, s, SLOTS)]                 = lane_act[l][s];
      assign slot_pos[slot_idx(l, s, SLOTS)*POS_W +: POS_W]     = lane_pos[l][s];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st       <= ST_IDLE;
      beat_cnt <= '0;
      beat_idx <= '0;
    end else begin
      case (st)
        ST_IDLE: if (start) begin
          st       <= ST_PLAY;
          beat_cnt <= '0;
          beat_idx <= '0;
        end
        ST_PLAY: if (abort) begin
          st       <= ST_IDLE;
          beat_cnt <= '0;
          beat_idx <= '0;
        end else begin
          if (tick)
            beat_cnt <= (beat_cnt == BW'(BEAT_TICKS - 1)) ? '0 : beat_cnt + 1'b1;
          if (spawn_beat)
            beat_idx <= beat_idx + 1'b1;
          // Judged on post-update values so DONE lines up with the final pulses.
          if (end_nxt && !(|lane_act_nxt))
            st <= ST_DONE;
        end
        ST_DONE: if (abort || !start) begin
          st       <= ST_IDLE;
          beat_cnt <= '0;
          beat_idx <= '0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
module tb_note_scheduler;

  localparam int POS_W = 10;

  logic        clk = 1'b0;
  logic        reset_n, tick, start, abort;
  logic [2:0]  song_data, song_addr, hit_req;
  logic [8:0]  slot_active;
  logic [89:0] slot_pos;
  logic [2:0]  hit_pulse, miss_pulse, overflow;
  logic [1:0]  state;
  logic [2:0]  rom [8];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign song_data = rom[song_addr];

  note_scheduler #(.BEAT_TICKS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .start      (start),
    .abort      (abort),
    .song_data  (song_data),
    .song_addr  (song_addr),
    .hit_req    (hit_req),
    .slot_active(slot_active),
    .slot_pos   (slot_pos),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .overflow   (overflow),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] posn(input int i);
    return 32'(slot_pos[i*POS_W +: POS_W]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 3'b000;
  endtask

  // Reset, then one start cycle; returns at a negedge with state=PLAY.
  task automatic restart();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0; hit_req = '0;
    cyc(2);
    reset_n = 1'b1;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0; hit_req = '0;
    clear_rom();

    // Spawn and advance
    rom[0] = 3'b101;
    rom[1] = 3'b011;
    restart();
    chk("start_state", 32'(state), 1);
    do_ticks(1);
    chk("spawn_active", 32'(slot_active), 32'h041);
    chk("spawn_pos0", posn(0), 0);
    chk("spawn_pos6", posn(6), 0);
    chk("spawn_addr", 32'(song_addr), 1);
    do_ticks(3);
    chk("adv3_pos0", posn(0), 3);
    chk("adv3_addr", 32'(song_addr), 1);
    do_ticks(1);
    chk("adv4_pos0", posn(0), 4);
    chk("adv4_pos6", posn(6), 4);
    chk("beat1_addr", 32'(song_addr), 2);
    chk("beat1_active", 32'(slot_active), 32'h04B);
    chk("beat1_pos1", posn(1), 0);

    // Reset mid-play with 4 notes
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("rst_state", 32'(state), 0);
    chk("rst_active", 32'(slot_active), 0);
    chk("rst_pos", 32'(|slot_pos), 0);
    chk("rst_addr", 32'(song_addr), 0);
    chk("rst_pulses", 32'({hit_pulse, miss_pulse, overflow}), 0);

    // Retire at bottom, then song end -> DONE -> IDLE
    clear_rom();
    rom[0] = 3'b001;
    restart();
    do_ticks(1);
    do_ticks(520);
    chk("ret_pos520", posn(0), 520);
    chk("ret_active", 32'(slot_active), 1);
    chk("ret_nomiss", 32'(miss_pulse), 0);
    do_ticks(1);
    chk("ret_cleared", 32'(slot_active), 0);
    chk("ret_miss", 32'(miss_pulse), 32'b001);
    chk("ret_done", 32'(state), 2);
    cyc(1);
    chk("ret_miss_1cyc", 32'(miss_pulse), 0);
    chk("done_to_idle", 32'(state), 0);

    // Overflow on the 4th spawn into a full lane
    for (int i = 0; i < 8; i++) rom[i] = 3'b001;
    restart();
    do_ticks(12);
    chk("ovf_full", 32'(slot_active), 32'h007);
    chk("ovf_none", 32'(overflow), 0);
    do_ticks(1);
    chk("ovf_pulse", 32'(overflow), 32'b001);
    chk("ovf_active", 32'(slot_active), 32'h007);
    chk("ovf_pos0", posn(0), 12);
    chk("ovf_pos1", posn(1), 8);
    chk("ovf_pos2", posn(2), 4);
    cyc(1);
    chk("ovf_1cyc", 32'(overflow), 0);

    // Hit window: note at 459 (in window) and 431 (below window) in lane 1
    clear_rom();
    rom[0] = 3'b010;
    rom[7] = 3'b010;
    restart();
    do_ticks(460);
    chk("hw_pos3", posn(3), 459);
    chk("hw_pos4", posn(4), 431);
    chk("hw_active", 32'(slot_active), 32'h018);
    hit_req = 3'b010;
    cyc(1);
    hit_req = '0;
    chk("hit1_pulse", 32'(hit_pulse), 32'b010);
    chk("hit1_nomiss", 32'(miss_pulse), 0);
    chk("hit1_active", 32'(slot_active), 32'h010);
    hit_req = 3'b010;
    cyc(1);
    hit_req = '0;
    chk("hit2_miss", 32'(miss_pulse), 32'b010);
    chk("hit2_nohit", 32'(hit_pulse), 0);
    chk("hit2_active", 32'(slot_active), 32'h010);
    chk("hit2_pos4", posn(4), 431);

    // Simultaneous hit and tick at HIT_HI, then abort with start
    clear_rom();
    rom[0] = 3'b100;
    rom[7] = 3'b001;
    restart();
    do_ticks(481);
    chk("sim_pos6", posn(6), 480);
    chk("sim_pos0", posn(0), 452);
    tick    = 1'b1;
    hit_req = 3'b100;
    cyc(1);
    tick    = 1'b0;
    hit_req = '0;
    chk("sim_hit", 32'(hit_pulse), 32'b100);
    chk("sim_active", 32'(slot_active), 32'h001);
    chk("sim_pos6_clr", posn(6), 0);
    chk("sim_pos0_adv", posn(0), 453);
    chk("sim_state", 32'(state), 1);
    abort = 1'b1;
    start = 1'b1;
    cyc(1);
    chk("abort_state", 32'(state), 0);
    chk("abort_active", 32'(slot_active), 0);
    chk("abort_addr", 32'(song_addr), 0);
    chk("abort_pulses", 32'({hit_pulse, miss_pulse, overflow}), 0);
    abort = 1'b0;
    start = 1'b0;
    cyc(1);
    chk("abort_hold", 32'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
